// File: rtl/cuckoo_lookup.sv
// Read-side lookup engine for a two-table cuckoo hash: probes table1 at h1(key),
// then table2 at h2(key), and reports hit/miss with saturating statistics.
module cuckoo_lookup #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [KEY_W-1:0] req_key,
    output logic             req_ready,
    output logic             t1_rd_en,
    output logic [IDX_W-1:0] t1_rd_addr,
    input  logic [KEY_W-1:0] t1_rd_data,
    input  logic             t1_rd_filled,
    output logic             t2_rd_en,
    output logic [IDX_W-1:0] t2_rd_addr,
    input  logic [KEY_W-1:0] t2_rd_data,
    input  logic             t2_rd_filled,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic             resp_table,
    output logic [IDX_W-1:0] resp_idx,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [2:0] {IDLE, PROBE1, WAIT1, PROBE2, WAIT2, RESP} state_t;

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] h1;
    logic [IDX_W-1:0] h2;
    logic             t1_hit;
    logic             t2_hit;

    assign h1     = key_q[IDX_W-1:0];
    assign h2     = key_q[2*IDX_W-1:IDX_W] ^ key_q[IDX_W-1:0];
    assign t1_hit = t1_rd_filled && (t1_rd_data == key_q);
    assign t2_hit = t2_rd_filled && (t2_rd_data == key_q);

    // Addresses follow the latched key; they only matter while a strobe is high.
    assign t1_rd_addr = h1;
    assign t2_rd_addr = h2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_table <= 1'b0;
            resp_idx   <= '0;
            t1_rd_en   <= 1'b0;
            t2_rd_en   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            t1_rd_en <= 1'b0;
            t2_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key_q     <= req_key;
                        req_ready <= 1'b0;
                        t1_rd_en  <= 1'b1;
                        state     <= PROBE1;
                    end
                end
                PROBE1: state <= WAIT1;
                WAIT1: begin
                    if (t1_hit) begin
                        resp_hit   <= 1'b1;
                        resp_table <= 1'b0;
                        resp_idx   <= h1;
                        resp_valid <= 1'b1;
                        hit_count  <= sat_inc(hit_count);
                        state      <= RESP;
                    end else begin
                        t2_rd_en <= 1'b1;
                        state    <= PROBE2;
                    end
                end
                PROBE2: state <= WAIT2;
                WAIT2: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                    if (t2_hit) begin
                        resp_hit   <= 1'b1;
                        resp_table <= 1'b1;
                        resp_idx   <= h2;
                        hit_count  <= sat_inc(hit_count);
                    end else begin
                        resp_hit   <= 1'b0;
                        resp_table <= 1'b0;
                        resp_idx   <= '0;
                        miss_count <= sat_inc(miss_count);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Self-checking bench for cuckoo_lookup: transaction-level reference model plus
// directed scenarios and randomized lookups against a modelled table storage.
module tb_cuckoo_lookup;

    localparam int KEY_W = 32;
    localparam int IDX_W = 4;
    localparam int D     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [KEY_W-1:0] req_key;
    logic             resp_ready;
    logic [KEY_W-1:0] t1_rd_data, t2_rd_data;
    logic             t1_rd_filled, t2_rd_filled;

    logic             req_ready, t1_rd_en, t2_rd_en, resp_valid, resp_hit, resp_table;
    logic [IDX_W-1:0] t1_rd_addr, t2_rd_addr, resp_idx;
    logic [15:0]      hit_count, miss_count;

    logic             b_req_ready, b_t1_rd_en, b_t2_rd_en, b_resp_valid, b_resp_hit, b_resp_table;
    logic [IDX_W-1:0] b_t1_rd_addr, b_t2_rd_addr, b_resp_idx;
    logic [1:0]       b_hit_count, b_miss_count;

    logic [KEY_W-1:0] t1_mem [D];
    logic [KEY_W-1:0] t2_mem [D];
    logic             t1_fill [D];
    logic             t2_fill [D];

    int checks = 0;
    int errors = 0;
    logic rand_rr = 1'b0;

    always #5 clk = ~clk;

    cuckoo_lookup #(.KEY_W(KEY_W), .IDX_W(IDX_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .t1_rd_en(t1_rd_en), .t1_rd_addr(t1_rd_addr), .t1_rd_data(t1_rd_data), .t1_rd_filled(t1_rd_filled),
        .t2_rd_en(t2_rd_en), .t2_rd_addr(t2_rd_addr), .t2_rd_data(t2_rd_data), .t2_rd_filled(t2_rd_filled),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_table(resp_table),
        .resp_idx(resp_idx), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter instance shares all inputs so saturation is observable quickly.
    cuckoo_lookup #(.KEY_W(KEY_W), .IDX_W(IDX_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(b_req_ready),
        .t1_rd_en(b_t1_rd_en), .t1_rd_addr(b_t1_rd_addr), .t1_rd_data(t1_rd_data), .t1_rd_filled(t1_rd_filled),
        .t2_rd_en(b_t2_rd_en), .t2_rd_addr(b_t2_rd_addr), .t2_rd_data(t2_rd_data), .t2_rd_filled(t2_rd_filled),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_hit(b_resp_hit), .resp_table(b_resp_table),
        .resp_idx(b_resp_idx), .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    // Table storage: one-cycle read latency, garbage when not strobed.
    always @(posedge clk) begin
        t1_rd_data   <= t1_rd_en ? t1_mem[t1_rd_addr] : $urandom;
        t1_rd_filled <= t1_rd_en ? t1_fill[t1_rd_addr] : 1'($urandom);
        t2_rd_data   <= t2_rd_en ? t2_mem[t2_rd_addr] : $urandom;
        t2_rd_filled <= t2_rd_en ? t2_fill[t2_rd_addr] : 1'($urandom);
    end

    always @(posedge clk) begin
        #1;
        if (rand_rr) resp_ready = ($urandom % 3) != 0;
    end

    function automatic int mh1(input logic [KEY_W-1:0] k);
        return int'(k % D);
    endfunction

    function automatic int mh2(input logic [KEY_W-1:0] k);
        return int'((k / D) % D) ^ int'(k % D);
    endfunction

    function automatic longint sat(input int n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : longint'(n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: ph counts cycles since accept (0 = idle), lat_exp is the RESP cycle.
    int               ph = 0;
    int               lat_exp = 0;
    int               nh = 0, nm = 0;
    logic             armed = 1'b0;
    logic             post_rst = 1'b0;
    logic [KEY_W-1:0] mkey = '0;
    logic             e_hit = 1'b0, e_tbl = 1'b0;
    int               e_idx = 0;

    task automatic chk_dut(input string tag, input logic rr, input logic rv, input logic e1, input logic e2,
                           input logic [IDX_W-1:0] a1, input logic [IDX_W-1:0] a2, input logic hit,
                           input logic tbl, input logic [IDX_W-1:0] idx, input logic [63:0] hc,
                           input logic [63:0] mc, input int cw);
        logic in_resp;
        in_resp = (ph != 0) && (ph == lat_exp);
        chk({tag, "_req_ready"}, rr, ph == 0);
        chk({tag, "_resp_valid"}, rv, in_resp);
        chk({tag, "_t1_rd_en"}, e1, ph == 1);
        chk({tag, "_t2_rd_en"}, e2, (ph == 3) && (lat_exp == 5));
        if (ph == 1) chk({tag, "_t1_rd_addr"}, a1, mh1(mkey));
        if (ph == 3 && lat_exp == 5) chk({tag, "_t2_rd_addr"}, a2, mh2(mkey));
        if (post_rst) begin
            chk({tag, "_rst_t1_addr"}, a1, 0);
            chk({tag, "_rst_t2_addr"}, a2, 0);
        end
        if (in_resp || post_rst) begin
            chk({tag, "_resp_hit"}, hit, e_hit);
            chk({tag, "_resp_table"}, tbl, e_tbl);
            chk({tag, "_resp_idx"}, idx, e_idx);
        end
        chk({tag, "_hit_count"}, hc, sat(nh, cw));
        chk({tag, "_miss_count"}, mc, sat(nm, cw));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk_dut("m", req_ready, resp_valid, t1_rd_en, t2_rd_en, t1_rd_addr, t2_rd_addr,
                    resp_hit, resp_table, resp_idx, 64'(hit_count), 64'(miss_count), 16);
            chk_dut("s", b_req_ready, b_resp_valid, b_t1_rd_en, b_t2_rd_en, b_t1_rd_addr, b_t2_rd_addr,
                    b_resp_hit, b_resp_table, b_resp_idx, 64'(b_hit_count), 64'(b_miss_count), 2);
        end
        if (rst) begin
            ph = 0; nh = 0; nm = 0; armed = 1'b1; post_rst = 1'b1;
            e_hit = 1'b0; e_tbl = 1'b0; e_idx = 0;
        end else if (armed) begin
            if (ph == 0) begin
                if (req_valid) begin
                    ph = 1; mkey = req_key; post_rst = 1'b0;
                    if (t1_fill[mh1(req_key)] && t1_mem[mh1(req_key)] == req_key) begin
                        e_hit = 1'b1; e_tbl = 1'b0; e_idx = mh1(req_key); lat_exp = 3;
                    end else if (t2_fill[mh2(req_key)] && t2_mem[mh2(req_key)] == req_key) begin
                        e_hit = 1'b1; e_tbl = 1'b1; e_idx = mh2(req_key); lat_exp = 5;
                    end else begin
                        e_hit = 1'b0; e_tbl = 1'b0; e_idx = 0; lat_exp = 5;
                    end
                end
            end else if (ph < lat_exp) begin
                ph++;
                if (ph == lat_exp) begin
                    if (e_hit) nh++;
                    else nm++;
                end
            end else if (resp_ready) begin
                ph = 0;
            end
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < D; i++) begin
            t1_mem[i] = '0; t2_mem[i] = '0; t1_fill[i] = 1'b0; t2_fill[i] = 1'b0;
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic run_req(input logic [KEY_W-1:0] key, input int gap, output int lat,
                           output logic hit, output logic tbl, output logic [IDX_W-1:0] idx);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_key   = key;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_key   = $urandom;
        wait_resp(lat);
        hit = resp_hit; tbl = resp_table; idx = resp_idx;
        for (int c = 0; c < 50; c++) begin
            if (resp_ready) break;
            @(negedge clk);
        end
        if (!resp_ready) chk("handshake_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        logic             hit, tbl;
        logic [IDX_W-1:0] idx;
        logic [KEY_W-1:0] k;
        int               a, b, mode, i;

        rst = 1'b1; req_valid = 1'b0; req_key = '0; resp_ready = 1'b1;
        clear_tables();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_hit_count", hit_count, 0);

        // table1 hit
        t1_mem[5] = 32'h25; t1_fill[5] = 1'b1;
        run_req(32'h25, 0, lat, hit, tbl, idx);
        chk("t1_lat", lat, 3);
        chk("t1_hit", hit, 1);
        chk("t1_table", tbl, 0);
        chk("t1_idx", idx, 5);
        chk("t1_hit_count", hit_count, 1);

        // table2 hit, table1 slot holds a different key
        t1_mem[5] = 32'h15;
        t2_mem[7] = 32'h25; t2_fill[7] = 1'b1;
        run_req(32'h25, 0, lat, hit, tbl, idx);
        chk("t2_lat", lat, 5);
        chk("t2_hit", hit, 1);
        chk("t2_table", tbl, 1);
        chk("t2_idx", idx, 7);

        // key 0 against unfilled zero slots must miss
        clear_tables();
        run_req(32'h0, 0, lat, hit, tbl, idx);
        chk("miss_lat", lat, 5);
        chk("miss_hit", hit, 0);
        chk("miss_table", tbl, 0);
        chk("miss_idx", idx, 0);
        chk("miss_count", miss_count, 1);
        chk("miss_hit_count", hit_count, 2);

        // backpressure with a second request pending throughout
        t1_mem[5] = 32'h25; t1_fill[5] = 1'b1;
        t1_mem[3] = 32'h33; t1_fill[3] = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; req_valid = 1'b1; req_key = 32'h25;
        @(negedge clk);
        chk("bp_accept_ready", req_ready, 1);
        @(posedge clk); #1;
        req_key = 32'h33;
        wait_resp(lat);
        chk("bp_lat", lat, 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_hit", resp_hit, 1);
            chk("bp_resp_idx", resp_idx, 5);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_second_ready", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_resp(lat);
        chk("bp2_lat", lat, 3);
        chk("bp2_idx", resp_idx, 3);
        chk("bp2_hit", resp_hit, 1);

        // reset while in WAIT2
        clear_tables();
        @(posedge clk); #1;
        req_valid = 1'b1; req_key = 32'h99;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_hit_count", hit_count, 0);
        chk("mid_rst_miss_count", miss_count, 0);

        // saturation of the narrow counters
        t1_mem[5] = 32'h25; t1_fill[5] = 1'b1;
        for (int n = 0; n < 5; n++) run_req(32'h25, 0, lat, hit, tbl, idx);
        chk("sat_hit_count", b_hit_count, 3);
        chk("sat_miss_count", b_miss_count, 0);
        chk("wide_hit_count", hit_count, 5);

        // randomized lookups with random backpressure and table contents
        rand_rr = 1'b1;
        for (int n = 0; n < 250; n++) begin
            repeat (2) begin
                i = $urandom % D; t1_mem[i] = $urandom; t1_fill[i] = 1'($urandom);
                i = $urandom % D; t2_mem[i] = $urandom; t2_fill[i] = 1'($urandom);
            end
            k = $urandom;
            mode = $urandom % 6;
            if (mode == 5) k = '0;
            a = mh1(k); b = mh2(k);
            case (mode)
                0: begin t1_mem[a] = k; t1_fill[a] = 1'b1; end
                1: begin t1_mem[a] = k ^ 32'h100; t1_fill[a] = 1'b1; t2_mem[b] = k; t2_fill[b] = 1'b1; end
                2: begin t1_mem[a] = k; t1_fill[a] = 1'b1; t2_mem[b] = k; t2_fill[b] = 1'b1; end
                3: begin t1_mem[a] = k; t1_fill[a] = 1'b0; t2_mem[b] = k; t2_fill[b] = 1'($urandom); end
                5: begin t1_mem[0] = '0; t1_fill[0] = 1'b0; t2_mem[0] = '0; t2_fill[0] = 1'b0; end
                default: ;
            endcase
            run_req(k, $urandom % 3, lat, hit, tbl, idx);
        end
        rand_rr = 1'b0;
        @(posedge clk); #1 resp_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
